// File: rtl/button_counter_param.sv
// button_counter_param: debounced 4-button command counter (binary/BCD, wrap/saturate, load)
//   clk, reset_p (async, active-high)
//   btn[3:0]   raw buttons: 0 inc, 1 dec, 2 rotate left, 3 rotate right
//   wrap       1 = wrap at limits, 0 = saturate
//   repeat_en  hold-to-repeat for inc/dec
//   load       synchronous load of load_value (beats every button)
//   count      counter value
//   evt[3:0]   one-cycle pulse per applied command
//   limit      one-cycle pulse when inc/dec hits max/zero
module button_counter_param #(
    parameter int WIDTH        = 16,
    parameter int BCD          = 0,
    parameter int DEBOUNCE_DIV = 17,
    parameter int HOLD_TICKS   = 50,
    parameter int REPEAT_TICKS = 10
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic [3:0]       btn,
    input  logic             wrap,
    input  logic             repeat_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic [3:0]       evt,
    output logic             limit
);
    localparam int ND = WIDTH / 4;
    localparam int SH = (BCD != 0) ? 4 : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

    logic [DEBOUNCE_DIV-1:0] div;
    logic                    msb_d, tick;
    logic [3:0]              s1, s2, armed, nd, db, db_d, pe, req;
    logic [1:0]              rp, fire;
    logic [HW-1:0]           hold [2];
    logic [RW-1:0]           rc [2];
    logic [WIDTH-1:0]        inc_v, dec_v, rol_v, ror_v;
    logic                    cy, bw, at_max, at_zero;
    logic [3:0]              dg;

    assign tick = div[DEBOUNCE_DIV-1] & ~msb_d;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            div   <= '0;
            msb_d <= 1'b0;
        end else begin
            div   <= div + 1'b1;
            msb_d <= div[DEBOUNCE_DIV-1];
        end
    end

    // A button only becomes visible after it has been seen released once,
    // so a button still held across reset never produces a phantom press.
    assign nd = s2 & armed;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            s1    <= '0;
            s2    <= '0;
            armed <= '0;
            db    <= '0;
            db_d  <= '0;
            pe    <= '0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            db_d <= db;
            pe   <= db & ~db_d;
            if (tick) begin
                db    <= nd;
                armed <= armed | ~s2;
            end
        end
    end

    // hold saturates at HOLD_TICKS; rc then paces the repeat interval.
    always_comb begin
        fire = '0;
        for (int i = 0; i < 2; i++)
            fire[i] = nd[i] & ((hold[i] == HW'(HOLD_TICKS - 1)) ||
                               (hold[i] == HW'(HOLD_TICKS) && rc[i] == RW'(REPEAT_TICKS - 1)));
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            rp <= '0;
            for (int i = 0; i < 2; i++) begin
                hold[i] <= '0;
                rc[i]   <= '0;
            end
        end else begin
            rp <= tick ? (fire & {2{repeat_en}}) : 2'b00;
            if (tick)
                for (int i = 0; i < 2; i++) begin
                    if (!nd[i]) begin
                        hold[i] <= '0;
                        rc[i]   <= '0;
                    end else if (hold[i] != HW'(HOLD_TICKS)) begin
                        hold[i] <= hold[i] + 1'b1;
                        rc[i]   <= '0;
                    end else
                        rc[i] <= (rc[i] == RW'(REPEAT_TICKS - 1)) ? '0 : rc[i] + 1'b1;
                end
        end
    end

    assign req = {pe[3:2], pe[1:0] | rp};

    // BCD digits above 9 are treated as 9 before the carry/borrow chain;
    // cy/bw end high only when every digit is 9 / 0.
    always_comb begin
        inc_v = count + 1'b1;
        dec_v = count - 1'b1;
        cy    = 1'b1;
        bw    = 1'b1;
        dg    = 4'd0;
        if (BCD != 0)
            for (int d = 0; d < ND; d++) begin
                dg = (count[4*d +: 4] > 4'd9) ? 4'd9 : count[4*d +: 4];
                inc_v[4*d +: 4] = cy ? ((dg == 4'd9) ? 4'd0 : dg + 4'd1) : dg;
                dec_v[4*d +: 4] = bw ? ((dg == 4'd0) ? 4'd9 : dg - 4'd1) : dg;
                cy = cy & (dg == 4'd9);
                bw = bw & (dg == 4'd0);
            end
    end

    assign at_max  = (BCD != 0) ? cy : &count;
    assign at_zero = ~|count;
    assign rol_v   = (count << SH) | (count >> (WIDTH - SH));
    assign ror_v   = (count >> SH) | (count << (WIDTH - SH));

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            count <= '0;
            evt   <= '0;
            limit <= 1'b0;
        end else if (load) begin
            count <= load_value;
            evt   <= '0;
            limit <= 1'b0;
        end else if (req[0]) begin
            count <= (at_max && !wrap) ? count : inc_v;
            evt   <= 4'b0001;
            limit <= at_max;
        end else if (req[1]) begin
            count <= (at_zero && !wrap) ? count : dec_v;
            evt   <= 4'b0010;
            limit <= at_zero;
        end else if (req[2]) begin
            count <= rol_v;
            evt   <= 4'b0100;
            limit <= 1'b0;
        end else if (req[3]) begin
            count <= ror_v;
            evt   <= 4'b1000;
            limit <= 1'b0;
        end else begin
            evt   <= '0;
            limit <= 1'b0;
        end
    end
endmodule
